mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-master arbiter and transaction sequencer for the single shared instruction/data memory of the multicycle RV32 core. Port 0 is the core's fetch/load/store path; port 1 is an auxiliary master (program loader or debug access). The block picks one pending request, drives one memory access of fixed latency, and returns a completion pulse with read data to the winning master. The core's main FSM stalls on `m0_gnt` / `m0_done`.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 1, cycles from `mem_en` to valid `mem_rdata`; legal range 1..8

Ports (X = 0, 1):
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `mX_req`  in  1  request; `mX_we`, `mX_addr`, `mX_wdata` must be stable while high and not yet granted
- `mX_we`  in  1  1 = write, 0 = read
- `mX_addr`  in  AW  byte address, passed through unmodified
- `mX_wdata`  in  DW  write data
- `mX_gnt`  out  1  one-cycle pulse: command accepted
- `mX_done`  out  1  one-cycle pulse: access complete
- `mX_rdata`  out  DW  read data, valid from the `mX_done` cycle until the next read completion on that port
- `mem_en`  out  1  memory access strobe, one cycle per transaction
- `mem_we`  out  1  write enable, qualified by `mem_en`
- `mem_addr`  out  AW  registered command address
- `mem_wdata`  out  DW  registered command write data
- `mem_rdata`  in  DW  memory read data, valid exactly `MEM_LAT` cycles after the `mem_en` cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `mX_req` is sampled high at the clock edge, arbitrate, latch the winner's command and owner ID, and go to ISSUE. Otherwise stay.
- ISSUE: `mem_en` = 1 and `mOwner_gnt` = 1 for exactly this cycle. Load latency counter with `MEM_LAT`-1. Next state is WAIT, or RESP when the count is 0 and the read data is captured this cycle.
- WAIT: decrement the counter. In the cycle `mem_rdata` is valid, capture it into the owner's rdata register (reads only) and go to RESP.
- RESP: `mOwner_done` = 1. Next state is IDLE.
- Writes: `mX_rdata` is unchanged; `done` still pulses.
- `mX_req` sampled high in IDLE is always a new transaction. A master wanting a single access deasserts req after its `gnt` cycle.
- Requests arriving while not in IDLE wait. Nothing is queued beyond the level-held req.
- The non-owner's gnt/done outputs are 0 at all times during a transaction.
- Simultaneous requests are resolved per Configuration.
- Reset mid-transaction: state returns to IDLE, all strobes drop, no `done` is issued, and the aborted access is lost.

## Timing
- Reset values: `mX_gnt`, `mX_done`, `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `mX_rdata` = 0; owner/last-grant register = 1; state = IDLE.
- Req sampled at edge 0 gives:
  - `gnt` and `mem_en` in cycle 1
  - `mem_rdata` valid in cycle 1+`MEM_LAT`, captured at the end of that cycle
  - `done` in cycle 2+`MEM_LAT`
  - IDLE in cycle 3+`MEM_LAT`
- Minimum spacing between `mem_en` pulses: 3+`MEM_LAT` cycles.
- All outputs are registered or decoded only from state and owner; there are no combinational paths from inputs to outputs.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie, the master not granted last wins. The last-grant register resets to 1, so port 0 wins the first tie. A continuously requesting master gets at most one transaction before the other is served.
- Not defined: fixed priority, port 0 always wins ties, and port 1 may starve. The last-grant register still exists but is ignored.

## Test plan
- `MEM_LAT`=1, m0 read of 0x100 returning 0xDEADBEEF:
  - `gnt`/`mem_en` in cycle 1, `m0_done` in cycle 3 with `m0_rdata`=0xDEADBEEF
  - back to IDLE in cycle 4
- m1 write 0x200 ← 0x12345678: one `mem_en` with `mem_we`=1 and correct addr/data, `m1_done` pulse, `m1_rdata` unchanged.
- Both reqs held high for 4 transactions:
  - with `ARB_ROUND_ROBIN_EN`, grant order is 0,1,0,1
  - without it, grant order is 0,0,0,0
- `MEM_LAT`=4: `done` arrives exactly 6 cycles after the req edge, and there is no second `mem_en` during WAIT.
- m1 requests while an m0 transaction is in WAIT: no m1 `gnt` until IDLE, then m1 is granted in the following cycle.
- Reset asserted in WAIT: all outputs 0 on the next cycle, no `done`, and a fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter and sequencer for the shared
// instruction/data memory of the multicycle RV32 core.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-low reset
//   mX_req/we/addr/wdata  : master X command (X = 0 core, 1 auxiliary)
//   mX_gnt, mX_done       : one-cycle accept / completion pulses
//   mX_rdata              : per-port read data, held until next read done
//   mem_en/we/addr/wdata  : registered command to the memory
//   mem_rdata             : memory read data, valid MEM_LAT cycles after mem_en
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise port 0 has fixed priority.

module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_done,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_done,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       owner;
   logic       pick;
   logic       we_q;
   logic [2:0] cnt;

   // Winner when at least one request is pending in IDLE.
   // owner doubles as the last-grant register.
`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      pick = 1'b0;
      if (m0_req && m1_req)
         pick = ~owner;
      else
         pick = m1_req;
   end
`else
   always_comb begin
      pick = 1'b0;
      pick = ~m0_req;
   end
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (m0_req || m1_req) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT:  if (cnt == 3'd0) state_nxt = RESP;
         RESP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= 1'b1;
         we_q      <= 1'b0;
         cnt       <= 3'd0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  owner     <= pick;
                  we_q      <= pick ? m1_we    : m0_we;
                  mem_addr  <= pick ? m1_addr  : m0_addr;
                  mem_wdata <= pick ? m1_wdata : m0_wdata;
               end
            end
            ISSUE: cnt <= 3'(MEM_LAT - 1);
            WAIT: begin
               // cnt reaches 0 in the cycle mem_rdata is valid
               if (cnt == 3'd0) begin
                  if (!we_q) begin
                     if (owner)
                        m1_rdata <= mem_rdata;
                     else
                        m0_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP: ;
            default: ;
         endcase
      end
   end

   assign mem_en  = (state == ISSUE);
   assign mem_we  = mem_en & we_q;
   assign m0_gnt  = mem_en & ~owner;
   assign m1_gnt  = mem_en & owner;
   assign m0_done = (state == RESP) & ~owner;
   assign m1_done = (state == RESP) & owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Instance dut uses MEM_LAT=1, instance dut4 uses MEM_LAT=4.

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;

   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_done, m1_gnt, m1_done;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        q_req, q_we;
   logic [31:0] q_addr, q_wdata;
   logic        q_gnt, q_done, q1_gnt, q1_done;
   logic [31:0] q_rdata, q1_rdata;
   logic        q_mem_en, q_mem_we;
   logic [31:0] q_mem_addr, q_mem_wdata, q_mem_rdata;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done),
      .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut4 (
      .clk(clk), .reset(reset),
      .m0_req(q_req), .m0_we(q_we), .m0_addr(q_addr),
      .m0_wdata(q_wdata), .m0_gnt(q_gnt), .m0_done(q_done),
      .m0_rdata(q_rdata),
      .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0),
      .m1_wdata(32'h0), .m1_gnt(q1_gnt), .m1_done(q1_done),
      .m1_rdata(q1_rdata),
      .mem_en(q_mem_en), .mem_we(q_mem_we), .mem_addr(q_mem_addr),
      .mem_wdata(q_mem_wdata), .mem_rdata(q_mem_rdata)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
   endfunction

   // Memory models: data is valid only in the exact latency cycle.
   logic        v1;
   logic [31:0] a1;
   logic [3:0]  v4;
   logic [31:0] a4;

   always @(posedge clk) begin
      v1 <= mem_en && !mem_we;
      if (mem_en) a1 <= mem_addr;
      v4 <= {v4[2:0], q_mem_en && !q_mem_we};
      if (q_mem_en) a4 <= q_mem_addr;
   end

   assign mem_rdata   = v1 ? memf(a1) : 32'hBAD0BAD0;
   assign q_mem_rdata = v4[3] ? memf(a4) : 32'hBAD0BAD0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          ng;
      int          both;
      int          en_cnt;
      int          dn_cnt;
      int          gcyc [4];
      logic [3:0]  order;
      logic [3:0]  exp_order;
      logic [31:0] exp_m1rd;

      reset = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      q_req = 0; q_we = 0; q_addr = 0; q_wdata = 0;
      repeat (3) cyc();

      check("rst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
      check("rst_done", {30'd0, m0_done, m1_done}, 32'd0);
      check("rst_mem_strb", {30'd0, mem_en, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_m1_rdata", m1_rdata, 32'd0);
      reset = 1'b1;
      cyc();

      // m0 read of 0x100
      m0_req = 1; m0_we = 0; m0_addr = 32'h100;
      cyc();
      check("rd_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
      check("rd_mem_en", {30'd0, mem_en, mem_we}, 32'd2);
      check("rd_mem_addr", mem_addr, 32'h100);
      m0_req = 0;
      cyc();
      check("rd_c2", {29'd0, mem_en, m0_done, m0_gnt}, 32'd0);
      cyc();
      check("rd_done", {30'd0, m0_done, m1_done}, 32'd2);
      check("rd_data", m0_rdata, 32'hDEADBEEF);
      cyc();
      check("rd_c4", {30'd0, m0_done, mem_en}, 32'd0);

      // m1 write 0x200 <- 0x12345678
      m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h12345678;
      cyc();
      check("wr_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
      check("wr_mem_en", {30'd0, mem_en, mem_we}, 32'd3);
      check("wr_mem_addr", mem_addr, 32'h200);
      check("wr_mem_wdata", mem_wdata, 32'h12345678);
      m1_req = 0; m1_we = 0;
      cyc();
      check("wr_c2_en", {31'd0, mem_en}, 32'd0);
      cyc();
      check("wr_done", {30'd0, m0_done, m1_done}, 32'd1);
      check("wr_rdata", m1_rdata, 32'd0);
      cyc();

      // both requesting, four transactions
      m0_req = 1; m0_addr = 32'h100;
      m1_req = 1; m1_addr = 32'h300;
      ng = 0; both = 0; order = 4'b0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         cyc();
         if (m0_gnt && m1_gnt) both++;
         if (m0_gnt || m1_gnt) begin
            order[3-ng] = m1_gnt;
            gcyc[ng] = c;
            ng++;
            if (ng == 4) begin
               m0_req = 0;
               m1_req = 0;
            end
         end
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = 4'b0101;
      exp_m1rd  = 32'h5A5A0300;
`else
      exp_order = 4'b0000;
      exp_m1rd  = 32'd0;
`endif
      check("arb_count", ng, 32'd4);
      check("arb_excl", both, 32'd0);
      check("arb_order", {28'd0, order}, {28'd0, exp_order});
      check("arb_spacing", gcyc[1] - gcyc[0], 32'd4);
      repeat (3) cyc();
      check("arb_m0_rdata", m0_rdata, 32'hDEADBEEF);
      check("arb_m1_rdata", m1_rdata, exp_m1rd);

      // m1 request arrives while m0 is in WAIT
      m0_req = 1; m0_addr = 32'h104;
      cyc();
      m0_req = 0;
      cyc();
      m1_req = 1; m1_we = 0; m1_addr = 32'h308;
      cyc();
      check("blk_c3", {30'd0, m1_gnt, m0_done}, 32'd1);
      check("blk_m0_data", m0_rdata, 32'h5A5A0104);
      cyc();
      check("blk_c4", {31'd0, m1_gnt}, 32'd0);
      cyc();
      check("blk_c5", {31'd0, m1_gnt}, 32'd1);
      m1_req = 0;
      cyc();
      cyc();
      check("blk_done", {30'd0, m0_done, m1_done}, 32'd1);
      check("blk_m1_data", m1_rdata, 32'h5A5A0308);
      cyc();

      // reset while in WAIT
      m0_req = 1; m0_addr = 32'h100;
      cyc();
      m0_req = 0;
      cyc();
      reset = 1'b0;
      cyc();
      check("rstw_strb", {28'd0, mem_en, mem_we, m0_gnt, m0_done},
            32'd0);
      check("rstw_addr", mem_addr, 32'd0);
      check("rstw_rdata", m0_rdata, 32'd0);
      reset = 1'b1;
      dn_cnt = 0;
      repeat (3) begin
         cyc();
         dn_cnt += int'(m0_done) + int'(m1_done) + int'(mem_en);
      end
      check("rstw_quiet", dn_cnt, 32'd0);
      m0_req = 1; m0_addr = 32'h10C;
      cyc();
      check("rstw_gnt", {31'd0, m0_gnt}, 32'd1);
      m0_req = 0;
      cyc();
      cyc();
      check("rstw_done", {31'd0, m0_done}, 32'd1);
      check("rstw_data", m0_rdata, 32'h5A5A010C);
      cyc();

      // MEM_LAT = 4 instance
      q_req = 1; q_we = 0; q_addr = 32'h140;
      cyc();
      check("lat4_gnt", {30'd0, q_gnt, q_mem_en}, 32'd3);
      q_req = 0;
      en_cnt = 0; dn_cnt = 0;
      for (int c = 2; c <= 5; c++) begin
         cyc();
         en_cnt += int'(q_mem_en);
         dn_cnt += int'(q_done);
      end
      check("lat4_no_en", en_cnt, 32'd0);
      check("lat4_early", dn_cnt, 32'd0);
      cyc();
      check("lat4_done", {31'd0, q_done}, 32'd1);
      check("lat4_data", q_rdata, 32'h5A5A0140);
      cyc();
      check("lat4_c7", {29'd0, q_done, q1_done, q1_gnt}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
